// File: rtl/dds_pkg.sv
// +----------------------------------------------------------------------------+
// | dds_pkg                                                                    |
// | Shared constants, lane-word layout, FSM states and the rounding helper     |
// | used to turn the split frequency product into a DDS phase increment.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package dds_pkg;

    // round(2^64 / F_CLK_HZ): Hz -> 32-bit phase increment with 32 guard bits
    localparam logic [36:0] PINC_K   = 37'd92233720369;
    localparam int unsigned F_CLK_HZ = 200_000_000;

    typedef struct packed {
        logic [31:0] poff;
        logic [31:0] pinc;
    } lane_word_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL1 = 3'd1,
        MUL2 = 3'd2,
        LANE = 3'd3,
        OUT  = 3'd4
    } state_t;

    // lo = frq*K[18:0], hi = frq*K[36:19]; bits above 63 never reach the result
    function automatic logic [31:0] pinc_round(input logic [50:0] lo, input logic [44:0] hi);
        logic [63:0] sum;
        sum = {13'd0, lo} + {hi, 19'd0} + 64'h0000_0000_8000_0000;
        return sum[63:32];
    endfunction

endpackage

`default_nettype wire

// File: rtl/dds_lane_phase_acc.sv
// +----------------------------------------------------------------------------+
// | dds_lane_phase_acc                                                         |
// | Builds the per-lane phase offsets (k*pinc)>>3 by repeated addition, one    |
// | lane per cycle after start_i; done_o pulses once all words are written.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module dds_lane_phase_acc
    import dds_pkg::*;
#(
    parameter int N_LANES = 8
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start_i,
    input  logic [31:0]             pinc_i,
    output logic [32*N_LANES-1:0]   poff_o,
    output logic                    done_o
);

    localparam int CW = $clog2(N_LANES);

    logic [CW-1:0] cnt_q;
    logic          run_q;
    logic          done_q;
    logic [34:0]   acc_q;
    logic [31:0]   poff_q [N_LANES];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
            acc_q  <= '0;
            for (int i = 0; i < N_LANES; i++) begin
                poff_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                run_q <= 1'b1;
                cnt_q <= '0;
                acc_q <= '0;
            end else if (run_q) begin
                // acc holds k*pinc with 3 extra bits so >>3 keeps a full 32-bit word
                poff_q[cnt_q] <= acc_q[34:3];
                acc_q         <= acc_q + {3'd0, pinc_i};
                cnt_q         <= cnt_q + 1'b1;
                if (cnt_q == CW'(N_LANES - 1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < N_LANES; k++) begin : g_poff
        assign poff_o[32*k +: 32] = poff_q[k];
    end

    assign done_o = done_q;

endmodule

`default_nettype wire

// File: rtl/dds_config_gen.sv
// +----------------------------------------------------------------------------+
// | dds_config_gen                                                             |
// | Converts a frequency in Hz into phase-increment/offset config words for    |
// | N_LANES parallel DDS lanes. Define DDS_CFG_RANGE_CHECK_EN to reject        |
// | requests above F_MAX_HZ with a cfg_err pulse.                              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module dds_config_gen
    import dds_pkg::*;
#(
    parameter int          N_LANES  = 8,
    parameter int unsigned F_MAX_HZ = 100_000_000
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [31:0]             frq_hz,
    input  logic                    frq_valid,
    output logic                    frq_ready,
    output logic [64*N_LANES-1:0]   cfg_tdata,
    output logic                    cfg_tvalid,
    input  logic                    cfg_tready,
    output logic                    busy,
    output logic                    cfg_err
);

    localparam logic [18:0] K_LO = PINC_K[18:0];
    localparam logic [17:0] K_HI = PINC_K[36:19];

    state_t                 state_q;
    logic [31:0]            frq_q;
    logic [50:0]            pp_lo_q;
    logic [44:0]            pp_hi_q;
    logic [31:0]            pinc_q;
    logic                   ready_q;
    logic                   valid_q;
    logic                   busy_q;
    logic [64*N_LANES-1:0]  tdata_q;

    logic                   w_accept;
    logic                   w_reject;
    logic                   w_lane_start;
    logic                   w_lane_done;
    logic [32*N_LANES-1:0]  w_poff;
    logic [64*N_LANES-1:0]  w_cfg;
    logic [50:0]            w_pp_lo;
    logic [44:0]            w_pp_hi;

    assign w_accept     = frq_valid & ready_q;
    assign w_lane_start = (state_q == MUL2);
    assign w_pp_lo      = {19'd0, frq_q} * {32'd0, K_LO};
    assign w_pp_hi      = {13'd0, frq_q} * {27'd0, K_HI};

    dds_lane_phase_acc #(
        .N_LANES (N_LANES)
    ) u_lane_acc (
        .aclk    (aclk),
        .aresetn (aresetn),
        .start_i (w_lane_start),
        .pinc_i  (pinc_q),
        .poff_o  (w_poff),
        .done_o  (w_lane_done)
    );

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane_word
        lane_word_t w_word;
        assign w_word.poff          = w_poff[32*k +: 32];
        assign w_word.pinc          = pinc_q;
        assign w_cfg[64*k +: 64]    = w_word;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            frq_q   <= '0;
            pp_lo_q <= '0;
            pp_hi_q <= '0;
            pinc_q  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            tdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (w_accept && !w_reject) begin
                        frq_q   <= frq_hz;
                        state_q <= MUL1;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                MUL1: begin
                    pp_lo_q <= w_pp_lo;
                    pp_hi_q <= w_pp_hi;
                    state_q <= MUL2;
                end
                MUL2: begin
                    pinc_q  <= pinc_round(pp_lo_q, pp_hi_q);
                    state_q <= LANE;
                end
                LANE: begin
                    if (w_lane_done) begin
                        tdata_q <= w_cfg;
                        valid_q <= 1'b1;
                        state_q <= OUT;
                    end
                end
                OUT: begin
                    if (cfg_tready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef DDS_CFG_RANGE_CHECK_EN
    logic err_q;

    assign w_reject = (frq_hz > F_MAX_HZ);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= w_accept & w_reject;
        end
    end

    assign cfg_err = err_q;
`else
    assign w_reject = 1'b0;
    assign cfg_err  = 1'b0;
`endif

    assign frq_ready  = ready_q;
    assign cfg_tvalid = valid_q;
    assign cfg_tdata  = tdata_q;
    assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_dds_config_gen.sv
// +----------------------------------------------------------------------------+
// | tb_dds_config_gen                                                          |
// | Directed self-checking bench for dds_config_gen with hand-computed words.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_dds_config_gen;

    logic         aclk;
    logic         aresetn;
    logic [31:0]  frq_hz;
    logic         frq_valid;
    logic         frq_ready;
    logic [511:0] cfg_tdata;
    logic         cfg_tvalid;
    logic         cfg_tready;
    logic         busy;
    logic         cfg_err;

    int n_checks = 0;
    int n_errors = 0;

    dds_config_gen u_dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .frq_hz     (frq_hz),
        .frq_valid  (frq_valid),
        .frq_ready  (frq_ready),
        .cfg_tdata  (cfg_tdata),
        .cfg_tvalid (cfg_tvalid),
        .cfg_tready (cfg_tready),
        .busy       (busy),
        .cfg_err    (cfg_err)
    );

    initial aclk = 1'b0;
    always #2.5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [511:0] mk_cfg(input logic [31:0] pinc, input logic [255:0] poff);
        logic [511:0] r;
        for (int k = 0; k < 8; k++) begin
            r[64*k +: 64] = {poff[32*k +: 32], pinc};
        end
        return r;
    endfunction

    // present a request; returns #1 after the acceptance edge
    task automatic send(input logic [31:0] f);
        frq_hz    = f;
        frq_valid = 1'b1;
        @(posedge aclk);
        #1;
        frq_valid = 1'b0;
    endtask

    task automatic wait_valid(output int edges);
        edges = -1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge aclk);
            #1;
            if (cfg_tvalid) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic count_valid(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge aclk);
            #1;
            if (cfg_tvalid) seen++;
        end
    endtask

    task automatic handshake();
        cfg_tready = 1'b1;
        @(posedge aclk);
        #1;
        cfg_tready = 1'b0;
    endtask

    initial begin
        int           edges;
        int           seen;
        logic [511:0] exp;
        logic [511:0] held;

        aresetn    = 1'b0;
        frq_hz     = '0;
        frq_valid  = 1'b0;
        cfg_tready = 1'b0;

        // reset state
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_ready", frq_ready, 0);
        chk("rst_tvalid", cfg_tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_tdata", cfg_tdata, 0);
        aresetn = 1'b1;
        #1;
        chk("rel_ready_low", frq_ready, 0);
        @(posedge aclk);
        #1;
        chk("rel_ready_high", frq_ready, 1);

        // 100 MHz: half-turn increment, lane k offset k/16 turn
        send(32'd100_000_000);
        chk("f100m_busy", busy, 1);
        chk("f100m_ready", frq_ready, 0);
        wait_valid(edges);
        chk("f100m_latency", edges, 11);
        exp = mk_cfg(32'h8000_0000, {32'h7000_0000, 32'h6000_0000, 32'h5000_0000, 32'h4000_0000,
                                     32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000});
        chk("f100m_tdata", cfg_tdata, exp);
        held = cfg_tdata;
        for (int i = 0; i < 5; i++) begin
            @(posedge aclk);
            #1;
            chk("stall_tdata", cfg_tdata, held);
            chk("stall_tvalid", cfg_tvalid, 1);
            chk("stall_ready", frq_ready, 0);
            chk("stall_busy", busy, 1);
        end
        handshake();
        chk("hs_tvalid", cfg_tvalid, 0);
        chk("hs_busy", busy, 0);
        chk("hs_ready", frq_ready, 1);

        // 1 Hz, with a second request held during busy that must be ignored
        send(32'd1);
        frq_hz    = 32'd999;
        frq_valid = 1'b1;
        wait_valid(edges);
        frq_valid = 1'b0;
        chk("f1_latency", edges, 11);
        exp = mk_cfg(32'h0000_0015, {32'd18, 32'd15, 32'd13, 32'd10, 32'd7, 32'd5, 32'd2, 32'd0});
        chk("f1_tdata", cfg_tdata, exp);
        handshake();
        count_valid(15, seen);
        chk("busy_req_ignored", seen, 0);
        chk("f1_retain", cfg_tdata, exp);
        chk("idle_busy", busy, 0);

        // reset during the 4th LANE cycle
        send(32'd100_000_000);
        repeat (5) @(posedge aclk);
        #1;
        aresetn = 1'b0;
        #1;
        chk("arst_tdata", cfg_tdata, 0);
        chk("arst_ready", frq_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_tvalid", cfg_tvalid, 0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("arst_rel_ready", frq_ready, 1);
        count_valid(20, seen);
        chk("arst_no_tvalid", seen, 0);

        // zero frequency
        send(32'd0);
        wait_valid(edges);
        chk("f0_latency", edges, 11);
        chk("f0_tvalid", cfg_tvalid, 1);
        chk("f0_tdata", cfg_tdata, 0);
        handshake();

        // one Hz above the range limit
        send(32'd100_000_001);
`ifdef DDS_CFG_RANGE_CHECK_EN
        chk("oor_err_pulse", cfg_err, 1);
        chk("oor_ready", frq_ready, 1);
        chk("oor_busy", busy, 0);
        @(posedge aclk);
        #1;
        chk("oor_err_clear", cfg_err, 0);
        count_valid(20, seen);
        chk("oor_no_tvalid", seen, 0);
        chk("oor_ready_kept", frq_ready, 1);
`else
        chk("oor_err_tied", cfg_err, 0);
        wait_valid(edges);
        chk("oor_latency", edges, 11);
        exp = mk_cfg(32'h8000_0015, {32'h7000_0012, 32'h6000_000F, 32'h5000_000D, 32'h4000_000A,
                                     32'h3000_0007, 32'h2000_0005, 32'h1000_0002, 32'h0000_0000});
        chk("oor_tdata", cfg_tdata, exp);
        handshake();
        chk("oor_ready_after", frq_ready, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/dds_config_gen.md
DDS_CONFIG_GEN -- requirements
Module: dds_config_gen

Interface
REQ-001 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Parameter N_LANES, default 8, SHALL set the number of DDS lanes fed; it is a power of two, and only the value 8 is supported.
REQ-003 Parameter F_MAX_HZ, default 100_000_000, SHALL set the highest legal requested frequency in Hz.
REQ-004 aclk  in  1  clock, 200 MHz.
REQ-005 aresetn  in  1  asynchronous active-low reset.
REQ-006 frq_hz  in  32  requested frequency, unsigned Hz.
REQ-007 frq_valid  in  1  frq_hz is valid.
REQ-008 frq_ready  out  1  block can accept frq_hz.
REQ-009 cfg_tdata  out  64*N_LANES  lane k occupies bits [64k+63:64k], holding {poff_k[31:0], pinc[31:0]}, matching the DDS s_axis_config_tdata layout.
REQ-010 cfg_tvalid  out  1  cfg_tdata is valid for all lanes; drives every lane's s_axis_config_tvalid.
REQ-011 cfg_tready  in  1  downstream accepts the config; all lanes accept together.
REQ-012 busy  out  1  a conversion is in progress.
REQ-013 cfg_err  out  1  one-cycle pulse when a request is rejected.

Function
REQ-014 The state machine SHALL have states IDLE, MUL1, MUL2, LANE, OUT.
REQ-015 A request SHALL be accepted only on an edge where frq_valid=1 and frq_ready=1; frq_ready SHALL be 1 only in IDLE.
REQ-016 On acceptance the FSM SHALL step IDLE->MUL1->MUL2->LANE, stay in LANE for 8 cycles (lane counter 0..7), then move to OUT.
REQ-017 cfg_tvalid SHALL rise on the 11th rising edge after the acceptance edge.
REQ-018 pinc SHALL equal (frq_hz*PINC_K + 2^31) >> 32, truncated to 32 bits: a 32x37-bit product computed over a 2-stage pipeline (MUL1, MUL2).
REQ-019 poff_k SHALL equal (k*pinc) >> 3, modulo 2^32, built with a 35-bit accumulator that adds pinc once per LANE cycle; no multiplier is used.
REQ-020 In OUT, cfg_tvalid SHALL be 1 and cfg_tdata SHALL be held stable until an edge where cfg_tready=1.
REQ-021 On that edge the FSM SHALL return to IDLE and cfg_tvalid SHALL fall; frq_ready SHALL be 1 in the following cycle.
REQ-022 Whether cfg_tready is high or low is irrelevant outside OUT.
REQ-023 busy SHALL be 1 in MUL1, MUL2, LANE and OUT, and 0 in IDLE.
REQ-024 frq_valid while busy SHALL be ignored; it is neither queued nor dropped with an error.
REQ-025 After a handshake, cfg_tdata SHALL retain its last value until the next OUT.
REQ-026 frq_hz=0 SHALL give pinc=0 and all poff_k=0.
REQ-027 pinc wrap-around above 2^32 SHALL be silent truncation.

Reset
REQ-028 aresetn=0 SHALL force state to IDLE and clear frq_ready, cfg_tvalid, cfg_tdata, busy, cfg_err, the accumulator and the lane counter, regardless of the current state.
REQ-029 frq_ready SHALL become 1 on the first aclk edge after aresetn deasserts.
REQ-030 Reset asserted in LANE or OUT SHALL abandon the pending configuration; no cfg_tvalid follows.

Configuration
REQ-031 With macro DDS_CFG_RANGE_CHECK_EN defined, an accepted frq_hz > F_MAX_HZ SHALL be rejected: cfg_err pulses for 1 cycle on the next edge, the FSM stays in IDLE, and no cfg_tvalid follows.
REQ-032 Without DDS_CFG_RANGE_CHECK_EN, every request SHALL be processed, cfg_err SHALL be tied to 0, and pinc SHALL wrap or alias per REQ-018.

Structure
REQ-033 The shared package dds_pkg SHALL hold PINC_K (37'd92233720369, equal to round(2^64/200e6)), F_CLK_HZ (200_000_000), the lane-word typedef {poff, pinc} and the FSM state enum.
REQ-034 The lane accumulator SHALL be a sub-module dds_lane_phase_acc (pinc in, 8 poff words out, start/done handshake).
REQ-035 The multiplier pipeline SHALL stay inline.

Verification
REQ-036 frq_hz=100_000_000 -> pinc=0x80000000 and poff_k=k*0x10000000 (k=0..7); cfg_tvalid rises on the 11th edge after acceptance.
REQ-037 frq_hz=1 -> pinc=0x00000015 and poff = 0,2,5,7,10,13,15,18.
REQ-038 frq_hz=0 -> all 512 bits of cfg_tdata = 0, cfg_tvalid asserted.
REQ-039 frq_hz=100_000_001, macro defined -> cfg_err pulse, no cfg_tvalid, frq_ready stays 1; macro undefined -> pinc=0x80000015.
REQ-040 cfg_tready held low 5 cycles in OUT -> cfg_tdata stable, frq_ready=0, busy=1; cfg_tready=1 -> IDLE next edge.
REQ-041 aresetn pulsed low at the 4th LANE cycle -> all outputs 0 at once; frq_ready=1 one edge after release; no cfg_tvalid.
